register_scoreboard: RTL
========================

REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 SHALL have parameter NUM_GPR, default 16, number of general-purpose registers tracked.
REQ-002 SHALL have parameter NUM_FPR, default 16, number of floating-point registers tracked.
REQ-003 SHALL have parameter IDX_W, default 4, register index width.
REQ-004 SHALL have parameter MAX_INFLIGHT, default 4, maximum outstanding writing instructions (1..7).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk  in  1  rising-edge clock.
REQ-007 SHALL have port rstn  in  1  asynchronous active-low reset.
REQ-008 SHALL have port flush  in  1  discard all pending writes (branch mispredict/abort).
REQ-009 SHALL have port iss_valid  in  1  decoded instruction offered for issue.
REQ-010 SHALL have port iss_ready  out  1  instruction accepted this cycle when iss_valid=1.
REQ-011 SHALL have ports from_gd, from_fd, to_gd, to_fd, from_gs, from_fs, from_gt, from_ft, from_ef, to_ef  in  1 each  register-usage flags of the offered instruction.
REQ-012 SHALL have ports d, s, t  in  IDX_W each  destination/source register indices.
REQ-013 SHALL have port wb_valid  in  1  writeback completing this cycle.
REQ-014 SHALL have ports wb_gd, wb_fd, wb_ef  in  1 each  writeback targets GPR[wb_idx] / FPR[wb_idx] / EFLAGS.
REQ-015 SHALL have port wb_idx  in  IDX_W  writeback register index.
REQ-016 SHALL have ports gpr_busy  out  NUM_GPR, fpr_busy  out  NUM_FPR, ef_busy  out  1  registered busy bits.
REQ-017 SHALL have port inflight  out  3  count of outstanding writing instructions.

Function
REQ-018 SHALL flag RAW hazard when any of: from_gd&gpr_busy[d], from_fd&fpr_busy[d], from_gs&gpr_busy[s], from_fs&fpr_busy[s], from_gt&gpr_busy[t], from_ft&fpr_busy[t], from_ef&ef_busy.
REQ-019 SHALL flag WAW hazard when any of: to_gd&gpr_busy[d], to_fd&fpr_busy[d], to_ef&ef_busy.
REQ-020 SHALL drive iss_ready = rstn & ~flush & ~RAW & ~WAW & ~(writer & inflight==MAX_INFLIGHT), writer = to_gd|to_fd|to_ef; combinational, zero latency.
REQ-021 SHALL, on accepted issue (iss_valid&iss_ready), set gpr_busy[d] if to_gd, fpr_busy[d] if to_fd, ef_busy if to_ef, next edge.
REQ-022 SHALL increment inflight by 1 per accepted issue with writer=1; non-writers (NOP, J, CMP-free branches) leave it unchanged.
REQ-023 SHALL, on wb_valid, clear the busy bits selected by wb_gd/wb_fd/wb_ef and decrement inflight by 1, next edge.
REQ-024 SHALL, when issue sets and writeback clears the same bit in one cycle, leave the bit set (set wins).
REQ-025 SHALL apply simultaneous increment and decrement as net zero.
REQ-026 SHALL ignore a decrement at inflight==0 (saturate at 0); writeback to a non-busy bit has no effect.
REQ-027 SHALL ignore indices >= NUM_GPR/NUM_FPR for set, clear and hazard check (treated as not busy).
REQ-028 SHALL, on flush, clear all busy bits and inflight next edge; flush overrides same-cycle issue and writeback.

Reset
REQ-029 SHALL, while rstn=0, hold gpr_busy=0, fpr_busy=0, ef_busy=0, inflight=0, iss_ready=0, asynchronously.
REQ-030 SHALL resume normal hazard evaluation on the first edge after rstn deasserts; no pending state survives reset mid-operation.

Configuration
REQ-031 SHALL support macro SCOREBOARD_WB_BYPASS_EN.
REQ-032 SHALL, with SCOREBOARD_WB_BYPASS_EN defined, evaluate REQ-018/019/020 against busy bits and inflight already reduced by the same-cycle writeback (wb resolves hazard in the same cycle).
REQ-033 SHALL, without SCOREBOARD_WB_BYPASS_EN, evaluate hazards against registered state only (one extra stall cycle after writeback).

Verification
REQ-034 SHALL verify: issue to_gd d=3, next cycle issue from_gs s=3 -> iss_ready=0 until wb_valid wb_gd wb_idx=3; then ready same cycle (bypass) or next cycle (no bypass).
REQ-035 SHALL verify: four writer issues to d=0..3 without writeback, MAX_INFLIGHT=4 -> inflight=4, fifth writer stalled, non-writer J issued (ready=1).
REQ-036 SHALL verify: issue to_gd d=5 with wb_gd wb_idx=5 same cycle while gpr_busy[5]=1 (bypass on) -> gpr_busy[5]=1 after edge, inflight unchanged.
REQ-037 SHALL verify: gpr_busy=0x00F0, ef_busy=1, inflight=3, assert flush with iss_valid -> iss_ready=0, all busy 0 and inflight 0 next edge.
REQ-038 SHALL verify: rstn pulled low mid-operation between edges -> all outputs 0 immediately; after release, from_ef issue accepted.
REQ-039 SHALL verify: wb_valid with inflight=0 and wb_idx=15 not busy -> inflight stays 0, no busy change.

Source files
------------

// File: rtl/register_scoreboard.sv
// Register scoreboard: tracks pending GPR/FPR/EFLAGS writes and gates issue on RAW/WAW hazards and in-flight limit.
// Optional SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback resolve hazards before issue is evaluated.
module register_scoreboard #(
  parameter int NUM_GPR      = 16,
  parameter int NUM_FPR      = 16,
  parameter int IDX_W        = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic               from_gd,
  input  logic               from_fd,
  input  logic               to_gd,
  input  logic               to_fd,
  input  logic               from_gs,
  input  logic               from_fs,
  input  logic               from_gt,
  input  logic               from_ft,
  input  logic               from_ef,
  input  logic               to_ef,
  input  logic [IDX_W-1:0]   d,
  input  logic [IDX_W-1:0]   s,
  input  logic [IDX_W-1:0]   t,
  input  logic               wb_valid,
  input  logic               wb_gd,
  input  logic               wb_fd,
  input  logic               wb_ef,
  input  logic [IDX_W-1:0]   wb_idx,
  output logic [NUM_GPR-1:0] gpr_busy,
  output logic [NUM_FPR-1:0] fpr_busy,
  output logic               ef_busy,
  output logic [2:0]         inflight
);

  logic [NUM_GPR-1:0] gpr_busy_q, gpr_busy_d, gpr_view, gpr_set, gpr_clr;
  logic [NUM_FPR-1:0] fpr_busy_q, fpr_busy_d, fpr_view, fpr_set, fpr_clr;
  logic [NUM_GPR-1:0] g_sel_d, g_sel_s, g_sel_t, g_sel_wb;
  logic [NUM_FPR-1:0] f_sel_d, f_sel_s, f_sel_t, f_sel_wb;
  logic               ef_busy_q, ef_busy_d, ef_view;
  logic [2:0]         inflight_q, inflight_d, inflight_view;
  logic               raw, waw, writer, accept, wb_dec, inc;

  // One-hot decode; indices beyond the register count decode to zero, so they never hit a busy bit.
  function automatic logic [NUM_GPR-1:0] dec_g(input logic [IDX_W-1:0] idx);
    logic [NUM_GPR-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_GPR; i++) if (int'(idx) == i) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [NUM_FPR-1:0] dec_f(input logic [IDX_W-1:0] idx);
    logic [NUM_FPR-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_FPR; i++) if (int'(idx) == i) r[i] = 1'b1;
    return r;
  endfunction

  assign g_sel_d  = dec_g(d);
  assign g_sel_s  = dec_g(s);
  assign g_sel_t  = dec_g(t);
  assign g_sel_wb = dec_g(wb_idx);
  assign f_sel_d  = dec_f(d);
  assign f_sel_s  = dec_f(s);
  assign f_sel_t  = dec_f(t);
  assign f_sel_wb = dec_f(wb_idx);

  assign gpr_clr = g_sel_wb & {NUM_GPR{wb_valid & wb_gd}};
  assign fpr_clr = f_sel_wb & {NUM_FPR{wb_valid & wb_fd}};
  assign wb_dec  = wb_valid & (inflight_q != 3'd0);

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign gpr_view      = gpr_busy_q & ~gpr_clr;
  assign fpr_view      = fpr_busy_q & ~fpr_clr;
  assign ef_view       = ef_busy_q & ~(wb_valid & wb_ef);
  assign inflight_view = inflight_q - {2'b00, wb_dec};
`else
  assign gpr_view      = gpr_busy_q;
  assign fpr_view      = fpr_busy_q;
  assign ef_view       = ef_busy_q;
  assign inflight_view = inflight_q;
`endif

  assign raw = (from_gd & |(gpr_view & g_sel_d)) | (from_fd & |(fpr_view & f_sel_d))
             | (from_gs & |(gpr_view & g_sel_s)) | (from_fs & |(fpr_view & f_sel_s))
             | (from_gt & |(gpr_view & g_sel_t)) | (from_ft & |(fpr_view & f_sel_t))
             | (from_ef & ef_view);
  assign waw = (to_gd & |(gpr_view & g_sel_d)) | (to_fd & |(fpr_view & f_sel_d))
             | (to_ef & ef_view);

  assign writer    = to_gd | to_fd | to_ef;
  assign iss_ready = rstn & ~flush & ~raw & ~waw
                   & ~(writer & (inflight_view == 3'(MAX_INFLIGHT)));
  assign accept    = iss_valid & iss_ready;
  assign inc       = accept & writer;

  assign gpr_set = g_sel_d & {NUM_GPR{accept & to_gd}};
  assign fpr_set = f_sel_d & {NUM_FPR{accept & to_fd}};

  // Set is applied after clear so a same-cycle issue keeps its bit.
  always_comb begin
    gpr_busy_d = (gpr_busy_q & ~gpr_clr) | gpr_set;
    fpr_busy_d = (fpr_busy_q & ~fpr_clr) | fpr_set;
    ef_busy_d  = (ef_busy_q & ~(wb_valid & wb_ef)) | (accept & to_ef);
    inflight_d = inflight_q + {2'b00, inc} - {2'b00, wb_dec};
    if (flush) begin
      gpr_busy_d = '0;
      fpr_busy_d = '0;
      ef_busy_d  = 1'b0;
      inflight_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gpr_busy_q <= '0;
      fpr_busy_q <= '0;
      ef_busy_q  <= 1'b0;
      inflight_q <= 3'd0;
    end else begin
      gpr_busy_q <= gpr_busy_d;
      fpr_busy_q <= fpr_busy_d;
      ef_busy_q  <= ef_busy_d;
      inflight_q <= inflight_d;
    end
  end

  assign gpr_busy = gpr_busy_q;
  assign fpr_busy = fpr_busy_q;
  assign ef_busy  = ef_busy_q;
  assign inflight = inflight_q;

endmodule
